// File: rtl/mul_hilo_unit.sv
// Iterative shift-and-add multiplier holding its product in HI/LO registers.
// Serves mfhi/mflo reads and stalls the datapath while a product is pending.
module mul_hilo_unit #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      count;
    logic               neg;
    logic               done_r;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] acc_final;

    // Magnitudes stay unsigned WIDTH bits, so the most negative value maps onto itself.
    always_comb begin
        mag_a = (signed_op && srca[WIDTH-1]) ? -srca : srca;
        mag_b = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;
    end

    always_comb begin
        pp = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (mplier[i]) begin
                pp = pp + (mcand << i);
            end
        end
        acc_next  = acc + pp;
        acc_final = neg ? -acc_next : acc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            neg    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        acc    <= '0;
                        count  <= CW'(N);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Further start pulses are ignored here; nothing is queued.
                    acc    <= acc_next;
                    mplier <= mplier >> RADIX_BITS;
                    mcand  <= mcand << RADIX_BITS;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        {hi, lo} <= acc_final;
                        done_r   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign done   = done_r;
    assign stall  = mf_req & busy;
    assign result = mf_sel ? hi : lo;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit: radix-1 instance for most steps,
// radix-2 instance for the restart-while-busy and shorter-latency step.
module tb_mul_hilo_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, signed_op, mf_req, mf_sel;
    logic [31:0] srca, srcb, result;
    logic        busy, done, stall;

    logic        start2, signed_op2, mf_req2, mf_sel2;
    logic [31:0] srca2, srcb2, result2;
    logic        busy2, done2, stall2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_hilo_unit #(.WIDTH(32), .RADIX_BITS(1)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .srca(srca), .srcb(srcb), .mf_req(mf_req), .mf_sel(mf_sel),
        .result(result), .busy(busy), .done(done), .stall(stall)
    );

    mul_hilo_unit #(.WIDTH(32), .RADIX_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .signed_op(signed_op2),
        .srca(srca2), .srcb(srcb2), .mf_req(mf_req2), .mf_sel(mf_sel2),
        .result(result2), .busy(busy2), .done(done2), .stall(stall2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        mf_req = 1'b1;
        mf_sel = 1'b1;
        #1;
        chk({tag, "_hi"}, result, exp_hi);
        mf_sel = 1'b0;
        #1;
        chk({tag, "_lo"}, result, exp_lo);
        mf_req = 1'b0;
    endtask

    // Launch on dut, count busy cycles, check the done pulse shape and latency.
    task automatic mul_a(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        int done_in_busy;
        start = 1'b1; signed_op = s; srca = a; srcb = b;
        tick();
        start = 1'b0;
        cyc = 0;
        done_in_busy = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (done !== 1'b0) done_in_busy++;
            cyc++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'd32);
        chk({tag, "_done_with_busy"}, 64'(done_in_busy), 64'd0);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd1);
        tick();
        chk({tag, "_done_single"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int cyc;
        int stall_cnt;
        int bad_result;
        int done_seen;

        reset = 1'b1;
        start = 0; signed_op = 0; srca = 0; srcb = 0; mf_req = 0; mf_sel = 0;
        start2 = 0; signed_op2 = 0; srca2 = 0; srcb2 = 0; mf_req2 = 0; mf_sel2 = 0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        mf_req = 1'b1;
        #1;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        read_a("rst", 32'h0, 32'h0);

        // Unsigned all-ones square
        mul_a("multu_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_a("multu_ff", 32'hFFFF_FFFE, 32'h0000_0001);

        // Signed cases
        mul_a("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5);
        read_a("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        mul_a("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000);
        read_a("mult_min", 32'h4000_0000, 32'h0000_0000);

        // Prime HI=1, LO=2 then read during a run
        mul_a("prime", 1'b0, 32'h8000_0001, 32'd2);
        read_a("prime", 32'h1, 32'h2);

        start = 1'b1; signed_op = 1'b0; srca = 32'd7; srcb = 32'd6;
        mf_req = 1'b1; mf_sel = 1'b0;
        #1;
        chk("launch_read_lo", result, 64'h2);
        chk("launch_stall", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0;
        cyc = 0; stall_cnt = 0; bad_result = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (stall === 1'b1) stall_cnt++;
            if (result !== 32'h2) bad_result++;
            cyc++;
            tick();
        end
        chk("stall_cycles", 64'(stall_cnt), 64'd32);
        chk("stall_old_lo", 64'(bad_result), 64'd0);
        chk("after_stall", {63'd0, stall}, 64'd0);
        chk("after_lo", result, 64'h2A);
        mf_sel = 1'b1;
        #1;
        chk("after_hi", result, 64'h0);
        mf_req = 1'b0;
        tick();

        // Reset in the middle of a run
        start = 1'b1; signed_op = 1'b0; srca = 32'd2; srcb = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        read_a("abort", 32'h0, 32'h0);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
            tick();
        end
        chk("abort_quiet", 64'(done_seen), 64'd0);
        mul_a("restart", 1'b0, 32'd4, 32'd4);
        read_a("restart", 32'h0, 32'h10);

        // Radix-2 instance: second start mid-run is ignored
        start2 = 1'b1; signed_op2 = 1'b0; srca2 = 32'h1234_5678; srcb2 = 32'h9;
        tick();
        start2 = 1'b0;
        cyc = 0; done_seen = 0;
        while (busy2 === 1'b1 && cyc < 200) begin
            if (cyc == 3) begin
                start2 = 1'b1; srca2 = 32'hDEAD_BEEF; srcb2 = 32'h7;
            end else begin
                start2 = 1'b0;
            end
            if (done2 !== 1'b0) done_seen++;
            cyc++;
            tick();
        end
        start2 = 1'b0;
        chk("r2_busy_cycles", 64'(cyc), 64'd16);
        chk("r2_done_with_busy", 64'(done_seen), 64'd0);
        chk("r2_done_pulse", {63'd0, done2}, 64'd1);
        mf_req2 = 1'b1; mf_sel2 = 1'b1;
        #1;
        chk("r2_hi", result2, 64'h0);
        mf_sel2 = 1'b0;
        #1;
        chk("r2_lo", result2, 64'hA3D7_0A38);
        mf_req2 = 1'b0;
        tick();
        chk("r2_done_single", {63'd0, done2}, 64'd0);
        chk("r2_no_requeue", {63'd0, busy2}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
